soc_io_fabric: RTL and testbench
================================

# soc_io_fabric

Parametrised I/O decode and read-return fabric that sits between the 65xx CPU core and its peripherals in the SoC top level. It replaces the fixed two-slot I/O page decode with N peripheral slots. It adds per-slot read wait states, driven through CPU `RDY`, and a registered read-data mux aligned to synchronous RAM/ROM. It also generates the peripheral clock strobe and aggregates interrupts into a single CPU IRQ.

## Interface
- `ADDR_W`, 20: CPU address width (16 for non-banked cores).
- `PAGE_W`, 8: page-field width, taken from `cpu_ab[ADDR_W-1 -: PAGE_W]`.
- `IOPAGE`, 8'h0d: page value that selects the I/O page.
- `SUB_W`, 6: subpage-field width, taken from `cpu_ab[ADDR_W-PAGE_W-1 -: SUB_W]`.
- `N_SLOTS`, 4: number of peripheral slots, 1..2^SUB_W-1. Slot s decodes at subpage s.
- `WAIT_W`, 2: width of each wait-state count.
- `SLOT_WAITS`, 0: packed `N_SLOTS*WAIT_W` read wait states. Slot s uses bits `[s*WAIT_W +: WAIT_W]`.
- `CLK_FREQ`, 16000000: system clock frequency in Hz.
- `PERIPH_FREQ`, 4000000: peripheral strobe rate in Hz. `CLK_FREQ` must be an integer multiple of it.

Ports:
- `clk` in 1: system clock. This is the block's only clock.
- `reset` in 1: synchronous, active-high reset.
- `cpu_ab` in ADDR_W: CPU address.
- `cpu_we_n` in 1: CPU write enable, low-true.
- `cpu_do` in 8: CPU write data. Used only for the mask register.
- `mem_do` in 8: RAM/ROM read data (synchronous, one cycle).
- `cpu_di` out 8: data returned to the CPU.
- `cpu_rdy` out 1: CPU `RDY`.
- `slot_cs_n` out N_SLOTS: per-slot chip select, low-true.
- `slot_do` in N_SLOTS*8: per-slot read data. Slot s is `[s*8 +: 8]`.
- `slot_irq_n` in N_SLOTS: per-slot IRQ, low-true.
- `ext_irq_n` in 1: external IRQ, low-true.
- `cpu_irq_n` out 1: aggregated IRQ to the CPU, registered.
- `pclk` out 1: one-`clk`-wide peripheral strobe.

## Operation
- **I/O page hit:** `io_hit` is asserted when the page field equals `IOPAGE`.
- **Slot select:** slot s is selected when `io_hit` is true and the subpage field equals s. The slot's `slot_cs_n[s]` is driven combinationally low for every cycle the address is held.
- **Unmapped subpages:** these return `mem_do`, matching the current default behaviour.
- **Wait-state FSM:** states are IDLE and WAIT, with counter `wcnt`.
  - IDLE: a read (`cpu_we_n=1`) to slot s with w = `SLOT_WAITS[s]` > 0 drives `cpu_rdy` low combinationally, loads `wcnt=w-1`, and moves to WAIT.
  - WAIT: `cpu_rdy=0` while `wcnt!=0`, and `wcnt` decrements each cycle. When `wcnt==0`, `cpu_rdy=1` and the FSM returns to IDLE.
  - The CPU holds its address while `cpu_rdy` is low.
- **Writes:** always zero-wait. The FSM never leaves IDLE on a write.
- **Read mux:**
  - On every cycle with `cpu_rdy=1`, the block registers `sel_q` (slot index, or "mem"; "status" only under the macro).
  - `cpu_di` is a combinational mux on `sel_q`, so data appears one cycle after the access completes, identical to RAM/ROM timing.
  - While `cpu_rdy=0`, `sel_q` is held.
- **Peripheral strobe:** counter `pcnt` has width `$clog2(CLK_FREQ/PERIPH_FREQ)`.
  - `pclk=1` in the cycle after `pcnt` reaches `ratio-1`; `pcnt` then wraps to 0.
  - If the ratio is 1, `pclk=1` every cycle after reset.
- **IRQ aggregation:** `cpu_irq_n <= ext_irq_n & &(slot_irq_n | ~mask)`. When the mask is not compiled in, all mask bits are 1.

## Timing
- **Reset values:**
  - `cpu_rdy=1`, FSM=IDLE, `wcnt=0`.
  - `sel_q`=mem, so `cpu_di=mem_do`.
  - `pclk=0`, `pcnt=0`.
  - `cpu_irq_n=1`.
  - mask = all ones.
- **Read latency:** a zero-wait read returns data 1 cycle later. A read with w waits completes after w stall cycles and returns data on cycle w+1.
- **IRQ latency:** `cpu_irq_n` follows its inputs with exactly 1 cycle of latency. There is no latching; level sensitivity is preserved.
- **Reset during WAIT:** in the same cycle, `cpu_rdy` is forced to 1, the FSM returns to IDLE, and the counter clears.
- **Consecutive waited reads:** back-to-back waited reads to the same slot each take a full wait sequence; one IDLE cycle with `rdy=1` separates them.
- **Decode precedence:** `slot_cs_n` depends on the address only, never on `cpu_rdy`.

## Configuration
- **`SOC_IO_IRQ_STATUS_EN` defined:**
  - Subpage `2^SUB_W-1` becomes the IRQ status/mask register.
  - Read returns `{pending[N_SLOTS-1:0]}` zero-extended, where pending = ~`slot_irq_n`, sampled at access. Reads are zero-wait.
  - A write loads mask = `cpu_do[N_SLOTS-1:0]`, where 1 means enabled.
- **`SOC_IO_IRQ_STATUS_EN` undefined:**
  - That subpage is unmapped and returns `mem_do`.
  - There is no mask register.
  - `cpu_irq_n` = AND of all IRQ inputs, registered.

## Structure
- **Shared package `soc_io_pkg`:**
  - `SEL_MEM` and `SEL_STATUS` select encodings.
  - The FSM state enum.
  - A `slot_wait(s)` helper function.
- **Sub-module `soc_pclk_gen`:** holds the strobe counter, is parametrised by ratio, and is reusable by other SoC tops.
- **Top module:** decode, FSM, read mux, and IRQ logic stay in `soc_io_fabric`.

## Test plan
- **Zero-wait slot read:** with `SLOT_WAITS=0` and `N_SLOTS=4`, read `0xD040` with slot 1 returning `0x5A` -> `slot_cs_n=4'b1101`, `cpu_rdy` stays 1, `cpu_di=0x5A` on the next cycle.
- **Waited slot read:** with slot 2 wait=3, read `0xD080` -> `cpu_rdy` low for exactly 3 cycles, then high; `cpu_di` = slot 2 data 1 cycle later.
- **Write never stalls:** write to slot 2 (wait=3) -> `cpu_rdy` never drops and `slot_cs_n[2]=0` for one cycle.
- **Reset during wait:** assert `reset` in the 2nd wait cycle -> next cycle `cpu_rdy=1`, `cpu_di=mem_do`, `cpu_irq_n=1`, `pclk=0`.
- **Peripheral strobe:** with a 16/4 MHz ratio -> after reset, `pclk` pulses once every 4 cycles, each pulse 1 cycle wide.
- **IRQ masking (macro on):** write `0x02` to subpage `0x3F`, then assert `slot_irq_n[0]` -> `cpu_irq_n` stays 1; assert `slot_irq_n[1]` -> `cpu_irq_n=0` one cycle later; status read returns `0x03`.

Source files
------------

// File: rtl/soc_io_pkg.sv
// Shared definitions for the SoC I/O fabric: read-mux select encodings,
// wait-state FSM states and the per-slot wait lookup helper.
package soc_io_pkg;

    localparam int SEL_W = 8;
    typedef logic [SEL_W-1:0] sel_t;

    // Slot indices occupy the low codes, so the special selects sit at the top.
    localparam sel_t SEL_MEM    = 8'hFF;
    localparam sel_t SEL_STATUS = 8'hFE;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } wait_state_t;

    function automatic logic [7:0] slot_wait(input logic [255:0] waits,
                                             input int          s,
                                             input int          wait_w);
        logic [255:0] shifted;
        shifted = waits >> (s * wait_w);
        return shifted[7:0] & 8'((1 << wait_w) - 1);
    endfunction

endpackage

// File: rtl/soc_pclk_gen.sv
// Peripheral clock strobe: a one-clk-wide pulse every RATIO system clocks,
// rising in the cycle after the counter reaches RATIO-1.
module soc_pclk_gen #(
    parameter int RATIO = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pclk
);

    generate
        if (RATIO <= 1) begin : g_every
            always_ff @(posedge clk) begin
                if (reset) pclk <= 1'b0;
                else       pclk <= 1'b1;
            end
        end else begin : g_count
            localparam int CW = $clog2(RATIO);
            localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

            logic [CW-1:0] pcnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    pcnt <= '0;
                    pclk <= 1'b0;
                end else begin
                    pclk <= (pcnt == LAST);
                    pcnt <= (pcnt == LAST) ? '0 : pcnt + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/soc_io_fabric.sv
// I/O page decode, per-slot read wait states, registered read-return mux,
// peripheral strobe and IRQ aggregation. Optional IRQ status/mask register
// at the top subpage is enabled by defining SOC_IO_IRQ_STATUS_EN.
module soc_io_fabric
    import soc_io_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int PAGE_W      = 8,
    parameter int IOPAGE      = 8'h0d,
    parameter int SUB_W       = 6,
    parameter int N_SLOTS     = 4,
    parameter int WAIT_W      = 2,
    parameter logic [N_SLOTS*WAIT_W-1:0] SLOT_WAITS = '0,
    parameter int CLK_FREQ    = 16000000,
    parameter int PERIPH_FREQ = 4000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    cpu_ab,
    input  logic                 cpu_we_n,
    input  logic [7:0]           cpu_do,
    input  logic [7:0]           mem_do,
    output logic [7:0]           cpu_di,
    output logic                 cpu_rdy,
    output logic [N_SLOTS-1:0]   slot_cs_n,
    input  logic [N_SLOTS*8-1:0] slot_do,
    input  logic [N_SLOTS-1:0]   slot_irq_n,
    input  logic                 ext_irq_n,
    output logic                 cpu_irq_n,
    output logic                 pclk
);

    localparam int RATIO = CLK_FREQ / PERIPH_FREQ;

    logic [PAGE_W-1:0]  page;
    logic [SUB_W-1:0]   sub;
    logic               io_hit;
    logic [N_SLOTS-1:0] slot_hit;
    sel_t               sel_now;
    sel_t               sel_q;
    logic [WAIT_W-1:0]  cur_wait;
    wait_state_t        state, state_next;
    logic [WAIT_W-1:0]  wcnt, wcnt_next;
    logic [N_SLOTS-1:0] irq_mask;
    logic               unused_ok;

    assign page   = cpu_ab[ADDR_W-1 -: PAGE_W];
    assign sub    = cpu_ab[ADDR_W-PAGE_W-1 -: SUB_W];
    assign io_hit = (page == PAGE_W'(IOPAGE));

    assign unused_ok = ^{cpu_ab, cpu_do};

`ifdef SOC_IO_IRQ_STATUS_EN
    logic               status_hit;
    logic [7:0]         pending8;
    logic [7:0]         status_q;
    logic [N_SLOTS-1:0] mask_in;
    logic [N_SLOTS-1:0] mask_q;

    assign status_hit = io_hit && (sub == SUB_W'((1 << SUB_W) - 1));
    assign irq_mask   = mask_q;
`else
    assign irq_mask = '1;
`endif

    always_comb begin
        slot_hit = '0;
        sel_now  = SEL_MEM;
        cur_wait = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            if (io_hit && (sub == SUB_W'(s))) begin
                slot_hit[s] = 1'b1;
                sel_now     = SEL_W'(s);
                cur_wait    = WAIT_W'(slot_wait(256'(SLOT_WAITS), s, WAIT_W));
            end
        end
`ifdef SOC_IO_IRQ_STATUS_EN
        if (status_hit) sel_now = SEL_STATUS;
`endif
    end

    assign slot_cs_n = ~slot_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

    // Reset overrides the stall combinationally so RDY is released in the reset cycle itself.
    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        cpu_rdy    = 1'b1;
        case (state)
            ST_IDLE: begin
                if (cpu_we_n && (|slot_hit) && (cur_wait != '0)) begin
                    cpu_rdy    = 1'b0;
                    wcnt_next  = cur_wait - WAIT_W'(1);
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wcnt != '0) begin
                    cpu_rdy   = 1'b0;
                    wcnt_next = wcnt - WAIT_W'(1);
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (reset) cpu_rdy = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)        sel_q <= SEL_MEM;
        else if (cpu_rdy) sel_q <= sel_now;
    end

`ifdef SOC_IO_IRQ_STATUS_EN
    always_comb begin
        pending8 = '0;
        mask_in  = '1;
        for (int s = 0; s < N_SLOTS && s < 8; s++) begin
            pending8[s] = ~slot_irq_n[s];
            mask_in[s]  = cpu_do[s];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_q <= '0;
            mask_q   <= '1;
        end else begin
            if (cpu_rdy && status_hit) status_q <= pending8;
            if (cpu_rdy && status_hit && !cpu_we_n) mask_q <= mask_in;
        end
    end
`endif

    // Data follows the registered select, giving the same one-cycle latency as RAM/ROM.
    always_comb begin
        cpu_di = mem_do;
        for (int s = 0; s < N_SLOTS; s++) begin
            if (sel_q == SEL_W'(s)) cpu_di = slot_do[s*8 +: 8];
        end
`ifdef SOC_IO_IRQ_STATUS_EN
        if (sel_q == SEL_STATUS) cpu_di = status_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) cpu_irq_n <= 1'b1;
        else       cpu_irq_n <= ext_irq_n & (&(slot_irq_n | ~irq_mask));
    end

    soc_pclk_gen #(
        .RATIO(RATIO)
    ) u_pclk_gen (
        .clk  (clk),
        .reset(reset),
        .pclk (pclk)
    );

endmodule

// File: tb/tb_soc_io_fabric.sv
// Directed bench for soc_io_fabric: decode, wait states, read return,
// strobe, IRQ aggregation and (with SOC_IO_IRQ_STATUS_EN) the mask register.
module tb_soc_io_fabric;

    localparam int N_SLOTS = 4;
    // slot3 = 1 wait, slot2 = 3 waits, slots 1 and 0 zero-wait
    localparam logic [7:0] WAITS = 8'b01_11_00_00;
    localparam logic [19:0] IDLE_ADDR = 20'h00000;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [19:0]          cpu_ab;
    logic                 cpu_we_n;
    logic [7:0]           cpu_do;
    logic [7:0]           mem_do;
    logic [7:0]           cpu_di;
    logic                 cpu_rdy;
    logic [N_SLOTS-1:0]   slot_cs_n;
    logic [N_SLOTS*8-1:0] slot_do;
    logic [N_SLOTS-1:0]   slot_irq_n;
    logic                 ext_irq_n;
    logic                 cpu_irq_n;
    logic                 pclk;

    int num_checks = 0;
    int num_fails  = 0;

    always #5 clk = ~clk;

    soc_io_fabric #(
        .N_SLOTS   (N_SLOTS),
        .SLOT_WAITS(WAITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_ab    (cpu_ab),
        .cpu_we_n  (cpu_we_n),
        .cpu_do    (cpu_do),
        .mem_do    (mem_do),
        .cpu_di    (cpu_di),
        .cpu_rdy   (cpu_rdy),
        .slot_cs_n (slot_cs_n),
        .slot_do   (slot_do),
        .slot_irq_n(slot_irq_n),
        .ext_irq_n (ext_irq_n),
        .cpu_irq_n (cpu_irq_n),
        .pclk      (pclk)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [19:0] addr, input logic we_n,
                                 input logic [7:0] wdata);
        cpu_ab   = addr;
        cpu_we_n = we_n;
        cpu_do   = wdata;
    endtask

    initial begin
        reset      = 1'b1;
        mem_do     = 8'hC3;
        slot_do    = {8'h44, 8'h33, 8'h5A, 8'h11};
        slot_irq_n = 4'hF;
        ext_irq_n  = 1'b1;
        applyStimulus(IDLE_ADDR, 1'b1, 8'h00);
        step();
        step();
        @(negedge clk);
        checkOutput("reset_rdy", 32'(cpu_rdy), 32'h1);
        checkOutput("reset_cs", 32'(slot_cs_n), 32'hF);
        checkOutput("reset_di", 32'(cpu_di), 32'hC3);
        checkOutput("reset_irq", 32'(cpu_irq_n), 32'h1);
        checkOutput("reset_pclk", 32'(pclk), 32'h0);
        reset = 1'b0;

        $display("[TB] peripheral strobe");
        for (int k = 1; k <= 8; k++) begin
            step();
            @(negedge clk);
            checkOutput($sformatf("pclk_%0d", k), 32'(pclk), 32'((k % 4) == 0));
        end

        $display("[TB] zero-wait read slot 1");
        step();
        applyStimulus(20'h0D040, 1'b1, 8'h00);
        @(negedge clk);
        checkOutput("zw_cs", 32'(slot_cs_n), 32'b1101);
        checkOutput("zw_rdy", 32'(cpu_rdy), 32'h1);
        step();
        applyStimulus(IDLE_ADDR, 1'b1, 8'h00);
        @(negedge clk);
        checkOutput("zw_di", 32'(cpu_di), 32'h5A);

        $display("[TB] waited read slot 2 after slot 0 read");
        step();
        applyStimulus(20'h0D000, 1'b1, 8'h00);
        @(negedge clk);
        checkOutput("s0_rdy", 32'(cpu_rdy), 32'h1);
        step();
        applyStimulus(20'h0D080, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("w3_rdy_low_%0d", i), 32'(cpu_rdy), 32'h0);
            checkOutput($sformatf("w3_di_hold_%0d", i), 32'(cpu_di), 32'h11);
            checkOutput($sformatf("w3_cs_%0d", i), 32'(slot_cs_n), 32'b1011);
            step();
        end
        @(negedge clk);
        checkOutput("w3_rdy_high", 32'(cpu_rdy), 32'h1);
        step();
        applyStimulus(IDLE_ADDR, 1'b1, 8'h00);
        @(negedge clk);
        checkOutput("w3_di", 32'(cpu_di), 32'h33);
        checkOutput("w3_rdy_after", 32'(cpu_rdy), 32'h1);

        $display("[TB] write to waited slot");
        step();
        applyStimulus(20'h0D080, 1'b0, 8'hAA);
        @(negedge clk);
        checkOutput("wr_rdy", 32'(cpu_rdy), 32'h1);
        checkOutput("wr_cs", 32'(slot_cs_n), 32'b1011);
        step();
        applyStimulus(IDLE_ADDR, 1'b1, 8'h00);
        @(negedge clk);
        checkOutput("wr_rdy_next", 32'(cpu_rdy), 32'h1);
        checkOutput("wr_cs_next", 32'(slot_cs_n), 32'hF);

        $display("[TB] back-to-back one-wait reads slot 3");
        step();
        applyStimulus(20'h0D0C0, 1'b1, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("w1_rdy_low_%0d", i), 32'(cpu_rdy), 32'h0);
            step();
            @(negedge clk);
            checkOutput($sformatf("w1_rdy_high_%0d", i), 32'(cpu_rdy), 32'h1);
            step();
        end
        applyStimulus(IDLE_ADDR, 1'b1, 8'h00);
        @(negedge clk);
        checkOutput("w1_di", 32'(cpu_di), 32'h44);

        $display("[TB] unmapped decode");
        step();
        mem_do = 8'h7E;
        applyStimulus(20'h0D100, 1'b1, 8'h00);
        @(negedge clk);
        checkOutput("unmap_cs", 32'(slot_cs_n), 32'hF);
        checkOutput("unmap_rdy", 32'(cpu_rdy), 32'h1);
        step();
        applyStimulus(20'h0E040, 1'b1, 8'h00);
        @(negedge clk);
        checkOutput("unmap_di", 32'(cpu_di), 32'h7E);
        checkOutput("page_0e_cs", 32'(slot_cs_n), 32'hF);
        step();
        applyStimulus(20'h1D040, 1'b1, 8'h00);
        @(negedge clk);
        checkOutput("page_1d_cs", 32'(slot_cs_n), 32'hF);
`ifndef SOC_IO_IRQ_STATUS_EN
        step();
        applyStimulus(20'h0DFC0, 1'b1, 8'h00);
        @(negedge clk);
        checkOutput("top_sub_cs", 32'(slot_cs_n), 32'hF);
        step();
        applyStimulus(IDLE_ADDR, 1'b1, 8'h00);
        @(negedge clk);
        checkOutput("top_sub_di", 32'(cpu_di), 32'h7E);
`endif
        step();
        applyStimulus(IDLE_ADDR, 1'b1, 8'h00);

        $display("[TB] irq aggregation");
        ext_irq_n = 1'b0;
        @(negedge clk);
        checkOutput("irq_latency", 32'(cpu_irq_n), 32'h1);
        step();
        @(negedge clk);
        checkOutput("irq_ext", 32'(cpu_irq_n), 32'h0);
        ext_irq_n  = 1'b1;
        slot_irq_n = 4'b1110;
        step();
        @(negedge clk);
        checkOutput("irq_slot0", 32'(cpu_irq_n), 32'h0);
        slot_irq_n = 4'hF;
        step();
        @(negedge clk);
        checkOutput("irq_release", 32'(cpu_irq_n), 32'h1);

`ifdef SOC_IO_IRQ_STATUS_EN
        $display("[TB] irq mask and status");
        step();
        applyStimulus(20'h0DFC0, 1'b0, 8'h02);
        @(negedge clk);
        checkOutput("mask_wr_rdy", 32'(cpu_rdy), 32'h1);
        checkOutput("mask_wr_cs", 32'(slot_cs_n), 32'hF);
        step();
        applyStimulus(IDLE_ADDR, 1'b1, 8'h00);
        slot_irq_n = 4'b1110;
        step();
        @(negedge clk);
        checkOutput("irq_masked", 32'(cpu_irq_n), 32'h1);
        slot_irq_n = 4'b1100;
        step();
        @(negedge clk);
        checkOutput("irq_enabled", 32'(cpu_irq_n), 32'h0);
        step();
        applyStimulus(20'h0DFC0, 1'b1, 8'h00);
        @(negedge clk);
        checkOutput("status_rdy", 32'(cpu_rdy), 32'h1);
        step();
        applyStimulus(IDLE_ADDR, 1'b1, 8'h00);
        slot_irq_n = 4'hF;
        @(negedge clk);
        checkOutput("status_di", 32'(cpu_di), 32'h03);
        step();
        @(negedge clk);
        checkOutput("irq_clear", 32'(cpu_irq_n), 32'h1);
`endif

        $display("[TB] reset during wait");
        step();
        ext_irq_n = 1'b0;
        mem_do    = 8'h5C;
        applyStimulus(20'h0D080, 1'b1, 8'h00);
        @(negedge clk);
        checkOutput("rw_rdy_c0", 32'(cpu_rdy), 32'h0);
        step();
        @(negedge clk);
        checkOutput("rw_rdy_c1", 32'(cpu_rdy), 32'h0);
        checkOutput("rw_irq_pre", 32'(cpu_irq_n), 32'h0);
        step();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rw_rdy_same", 32'(cpu_rdy), 32'h1);
        step();
        @(negedge clk);
        checkOutput("rw_rdy", 32'(cpu_rdy), 32'h1);
        checkOutput("rw_di", 32'(cpu_di), 32'h5C);
        checkOutput("rw_irq", 32'(cpu_irq_n), 32'h1);
        checkOutput("rw_pclk", 32'(pclk), 32'h0);
        checkOutput("rw_cs", 32'(slot_cs_n), 32'b1011);
        reset     = 1'b0;
        ext_irq_n = 1'b1;
        applyStimulus(IDLE_ADDR, 1'b1, 8'h00);
        step();
        @(negedge clk);
        checkOutput("rw_idle_rdy", 32'(cpu_rdy), 32'h1);
        step();
        applyStimulus(20'h0D0C0, 1'b1, 8'h00);
        @(negedge clk);
        checkOutput("rw_restart_low", 32'(cpu_rdy), 32'h0);
        step();
        @(negedge clk);
        checkOutput("rw_restart_high", 32'(cpu_rdy), 32'h1);
        step();
        applyStimulus(IDLE_ADDR, 1'b1, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
